ddr3_ring_sequencer: RTL

- Slot-based circular-buffer sequencer placed between the ingress/egress ping-pong FIFOs and the DDR3 application-interface stage.
- DDR3 region is split into NUM_SLOTS fixed slots of SLOT_DWORDS each; every ingress chunk lands in the next free slot, and its actual size is recorded.
- Decides when a write or read runs, supplies its dword address, and gates the FIFO ready lines so that exactly one chunk moves per grant.
- Egress replays slots in FIFO order with their recorded sizes.

---
 rtl/ddr3_ring_pkg.sv | 30 +++
 rtl/ddr3_slot_desc_fifo.sv | 59 +++++
 rtl/ddr3_ring_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_ring_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr3_ring_pkg : shared types and constants for the DDR3 slot ring           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ddr3_ring_pkg;

  localparam int SLOT_DWORDS = 2048;
  localparam int NUM_SLOTS   = 16;
  localparam int SIZE_W      = 24;

  typedef logic [SIZE_W-1:0] size_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_BUSY = 3'd2,
    ST_WR_DONE = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_BUSY = 3'd5,
    ST_RD_DONE = 3'd6
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage
`default_nettype wire

// File: rtl/ddr3_slot_desc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr3_slot_desc_fifo : show-ahead FIFO of recorded slot sizes                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ddr3_slot_desc_fifo
  import ddr3_ring_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  size_t               din_i,
  output size_t               head_o,
  output logic [DEPTH_LOG2:0] count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  size_t                 mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Push and pop together on a full FIFO replaces the oldest entry.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ddr3_ring_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr3_ring_sequencer : slot ring arbiter between ping-pong FIFOs and DDR3 IF |
// | Option DDR3_RING_OVERWRITE_EN: drop oldest slot on write when full.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ddr3_ring_sequencer
  import ddr3_ring_pkg::*;
#(
  parameter int MEM_ADDR_DEPTH   = 28,
  parameter int SLOT_DWORDS_LOG2 = 11,
  parameter int NUM_SLOTS_LOG2   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic                        i_clear,
  input  logic [MEM_ADDR_DEPTH-3:0]   i_base_dword_addr,
  input  logic                        i_if_idle,
  input  logic                        i_ingress_rdy,
  input  logic [23:0]                 i_ingress_size,
  input  logic                        i_ingress_act,
  output logic                        o_ingress_en,
  output logic [MEM_ADDR_DEPTH-3:0]   o_ingress_dword_addr,
  output logic                        o_ingress_rdy,
  input  logic [1:0]                  i_egress_rdy,
  input  logic [23:0]                 i_egress_fifo_size,
  input  logic [1:0]                  i_egress_act,
  output logic                        o_egress_en,
  output logic [MEM_ADDR_DEPTH-3:0]   o_egress_dword_addr,
  output logic [1:0]                  o_egress_rdy,
  output logic [23:0]                 o_egress_size,
  output logic [NUM_SLOTS_LOG2:0]     o_fill_slots,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_err_oversize
`ifdef DDR3_RING_OVERWRITE_EN
  ,
  output logic                        o_overrun
`endif
);

  localparam int AW       = MEM_ADDR_DEPTH - 2;
  localparam int IW       = NUM_SLOTS_LOG2;
  localparam int SLOT_SZ  = 1 << SLOT_DWORDS_LOG2;
  localparam int SLOT_CNT = 1 << NUM_SLOTS_LOG2;

  state_t        state_q;
  grant_t        last_grant_q;
  logic [IW-1:0] wr_idx_q;
  logic [IW-1:0] rd_idx_q;
  size_t         wr_size_q;
  logic          ing_gate_q;
  logic          egr_gate_q;
  logic          ing_act_q;
  logic          egr_act_q;
  logic          err_q;
  logic          ovr_q;

  size_t         w_head;
  logic [IW:0]   w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_clear;
  logic          w_room;
  logic          w_size_legal;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_grant_wr;
  logic          w_grant_rd;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  ddr3_slot_desc_fifo #(
    .DEPTH_LOG2 (NUM_SLOTS_LOG2)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_clear),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (wr_size_q),
    .head_o  (w_head),
    .count_o (w_count)
  );

  assign o_fill_slots   = w_count;
  assign o_full         = (w_count == (IW + 1)'(SLOT_CNT));
  assign o_empty        = (w_count == '0);
  assign o_err_oversize = err_q;
  assign o_ingress_rdy  = ing_gate_q & i_ingress_rdy;
  assign o_egress_rdy   = {2{egr_gate_q}} & i_egress_rdy;

  assign w_wr_addr = i_base_dword_addr + (AW'(wr_idx_q) << SLOT_DWORDS_LOG2);
  assign w_rd_addr = i_base_dword_addr + (AW'(rd_idx_q) << SLOT_DWORDS_LOG2);

`ifdef DDR3_RING_OVERWRITE_EN
  assign w_room    = 1'b1;
  assign w_pop     = i_if_idle && ((state_q == ST_RD_DONE) || (state_q == ST_WR_DONE && o_full));
  assign o_overrun = ovr_q;
`else
  assign w_room    = !o_full;
  assign w_pop     = i_if_idle && (state_q == ST_RD_DONE);
`endif

  assign w_push       = i_if_idle && (state_q == ST_WR_DONE);
  assign w_clear      = i_clear && (state_q == ST_IDLE);
  assign w_size_legal = (i_ingress_size != '0) && (i_ingress_size <= size_t'(SLOT_SZ));
  assign w_wr_ok      = i_enable && i_ingress_rdy && w_room && i_if_idle && w_size_legal;
  assign w_rd_ok      = i_enable && (|i_egress_rdy) && !o_empty && i_if_idle &&
                        (i_egress_fifo_size >= w_head);
  // On a tie the side not served last wins.
  assign w_grant_wr   = w_wr_ok && (!w_rd_ok || (last_grant_q == GRANT_RD));
  assign w_grant_rd   = w_rd_ok && !w_grant_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= ST_IDLE;
      last_grant_q         <= GRANT_RD;
      wr_idx_q             <= '0;
      rd_idx_q             <= '0;
      wr_size_q            <= '0;
      ing_gate_q           <= 1'b0;
      egr_gate_q           <= 1'b0;
      ing_act_q            <= 1'b0;
      egr_act_q            <= 1'b0;
      err_q                <= 1'b0;
      ovr_q                <= 1'b0;
      o_ingress_en         <= 1'b0;
      o_egress_en          <= 1'b0;
      o_ingress_dword_addr <= '0;
      o_egress_dword_addr  <= '0;
      o_egress_size        <= '0;
    end else begin
      ing_act_q <= i_ingress_act;
      egr_act_q <= |i_egress_act;
      case (state_q)
        ST_IDLE: begin
          if (i_clear) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
          end else begin
            if (i_ingress_rdy && !w_size_legal) begin
              err_q <= 1'b1;
            end
            if (w_grant_wr) begin
              o_ingress_en         <= 1'b1;
              ing_gate_q           <= 1'b1;
              o_ingress_dword_addr <= w_wr_addr;
              state_q              <= ST_WR_REQ;
            end else if (w_grant_rd) begin
              o_egress_en         <= 1'b1;
              egr_gate_q          <= 1'b1;
              o_egress_dword_addr <= w_rd_addr;
              o_egress_size       <= w_head;
              state_q             <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (i_ingress_act && !ing_act_q) begin
            wr_size_q    <= i_ingress_size;
            o_ingress_en <= 1'b0;
            ing_gate_q   <= 1'b0;
            state_q      <= ST_WR_BUSY;
          end
        end
        ST_WR_BUSY: begin
          if (!i_ingress_act) begin
            state_q <= ST_WR_DONE;
          end
        end
        ST_WR_DONE: begin
          if (i_if_idle) begin
            wr_idx_q     <= wr_idx_q + IW'(1);
            last_grant_q <= GRANT_WR;
`ifdef DDR3_RING_OVERWRITE_EN
            if (o_full) begin
              rd_idx_q <= rd_idx_q + IW'(1);
              ovr_q    <= 1'b1;
            end
`endif
            state_q      <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          if ((|i_egress_act) && !egr_act_q) begin
            o_egress_en <= 1'b0;
            egr_gate_q  <= 1'b0;
            state_q     <= ST_RD_BUSY;
          end
        end
        ST_RD_BUSY: begin
          if (i_egress_act == 2'b00) begin
            state_q <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: begin
          if (i_if_idle) begin
            rd_idx_q     <= rd_idx_q + IW'(1);
            last_grant_q <= GRANT_RD;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
